data_mem_ws: RTL and testbench

//  Word-addressed data memory with wait states, byte-enable stores and error reporting.

---
 rtl/data_mem_ws_if.sv | 23 ++
 rtl/data_mem_ws.sv | 168 ++++++++++++++++
 tb/tb_data_mem_ws.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_ws_if.sv
// Valid/ready request and one-strobe response bus between the CPU load/store
// stage (master) and the wait-state data memory (slave).
interface data_mem_ws_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_ws.sv
// Word-addressed data memory with programmable wait states, byte-enable stores and
// error reporting. Optional per-byte even parity is enabled by defining DMEM_PARITY_EN.
module data_mem_ws #(
  parameter int         ADDR_BITS    = 8,
  parameter int         WAIT_STATES  = 1,
  parameter logic [3:0] BLOCK_REGION = 4'h4
) (
  input  logic         clk,
  input  logic         reset,
  data_mem_ws_if.slave bus,
  output logic         busy,
  output logic         par_err
);
  localparam int DEPTH = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        ready_reg;
  logic        busy_reg;
  logic        rsp_valid_reg;
  logic        err_reg;
  logic        load_ok_reg;
  logic        wr_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  be_reg;

  logic                 accept;
  logic                 commit;
  logic                 addr_err;
  logic                 wr_en;
  logic                 rd_en;
  logic [ADDR_BITS-1:0] idx;
  logic [31:0]          rd_word;
  logic                 par_bad;

  assign accept   = bus.req_valid && ready_reg;
  assign commit   = (state == S_WAIT) && (cnt == 4'd0);
  assign idx      = addr_reg[ADDR_BITS+1:2];
  // Upper-bit check rejects out-of-range addresses instead of aliasing them.
  assign addr_err = (addr_reg[31:28] == BLOCK_REGION) ||
                    (addr_reg[1:0] != 2'b00) ||
                    (addr_reg[31:ADDR_BITS+2] != '0);
  assign wr_en    = commit && wr_reg && !addr_err;
  assign rd_en    = commit && !wr_reg && !addr_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      cnt           <= 4'd0;
      ready_reg     <= 1'b1;
      busy_reg      <= 1'b0;
      rsp_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
      load_ok_reg   <= 1'b0;
      wr_reg        <= 1'b0;
      addr_reg      <= 32'd0;
      wdata_reg     <= 32'd0;
      be_reg        <= 4'd0;
    end else begin
      rsp_valid_reg <= 1'b0;
      case (state)
        S_IDLE, S_RESP: begin
          if (accept) begin
            wr_reg    <= bus.req_wr;
            addr_reg  <= bus.req_addr;
            wdata_reg <= bus.req_wdata;
            be_reg    <= bus.req_be;
            cnt       <= 4'(WAIT_STATES);
            state     <= S_WAIT;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b1;
          end else begin
            state     <= S_IDLE;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state         <= S_RESP;
            rsp_valid_reg <= 1'b1;
            ready_reg     <= 1'b1;
            busy_reg      <= 1'b1;
            err_reg       <= addr_err;
            load_ok_reg   <= !wr_reg && !addr_err;
          end
        end
        default: begin
          state     <= S_IDLE;
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // One RAM per byte lane so a byte-enable store maps onto plain block RAM writes.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_byte;

      always_ff @(posedge clk) begin
        if (wr_en && be_reg[gi]) begin
          mem[idx] <= wdata_reg[8*gi +: 8];
        end
        if (rd_en) begin
          rd_byte <= mem[idx];
        end
      end

      assign rd_word[8*gi +: 8] = rd_byte;
    end
  endgenerate

`ifdef DMEM_PARITY_EN
  logic [3:0] rd_par;
  logic [3:0] calc_par;
  logic       par_err_reg;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_par
      logic par_mem [DEPTH];
      logic rd_p;

      always_ff @(posedge clk) begin
        if (wr_en && be_reg[gi]) begin
          par_mem[idx] <= ^wdata_reg[8*gi +: 8];
        end
        if (rd_en) begin
          rd_p <= par_mem[idx];
        end
      end

      assign rd_par[gi]   = rd_p;
      assign calc_par[gi] = ^rd_word[8*gi +: 8];
    end
  endgenerate

  // Data is read registered, so the parity verdict is formed during RESP.
  assign par_bad = load_ok_reg && (rd_par != calc_par);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_err_reg <= 1'b0;
    end else if ((state == S_RESP) && par_bad) begin
      par_err_reg <= 1'b1;
    end
  end

  assign par_err = par_err_reg;
`else
  assign par_bad = 1'b0;
  assign par_err = 1'b0;
`endif

  assign bus.req_ready = ready_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_rdata = load_ok_reg ? rd_word : 32'd0;
  assign bus.rsp_err   = err_reg || par_bad;
  assign busy          = busy_reg;
endmodule

// File: tb/tb_data_mem_ws.sv
// Self-checking bench for data_mem_ws: vector table plus scoreboard on a WAIT_STATES=2
// instance, and three extra instances (WAIT_STATES 0, 1, 3) for latency/back-to-back.
module tb_data_mem_ws;
  localparam int WS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  data_mem_ws_if bus ();
  data_mem_ws_if if0 ();
  data_mem_ws_if if1 ();
  data_mem_ws_if if3 ();

  logic       busy, par_err;
  logic [2:0] a_busy, a_par;

  data_mem_ws #(.ADDR_BITS(8), .WAIT_STATES(WS), .BLOCK_REGION(4'h4)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy), .par_err(par_err));
  data_mem_ws #(.ADDR_BITS(8), .WAIT_STATES(0), .BLOCK_REGION(4'h4)) dut_ws0 (
    .clk(clk), .reset(reset), .bus(if0), .busy(a_busy[0]), .par_err(a_par[0]));
  data_mem_ws #(.ADDR_BITS(8), .WAIT_STATES(1), .BLOCK_REGION(4'h4)) dut_ws1 (
    .clk(clk), .reset(reset), .bus(if1), .busy(a_busy[1]), .par_err(a_par[1]));
  data_mem_ws #(.ADDR_BITS(8), .WAIT_STATES(3), .BLOCK_REGION(4'h4)) dut_ws3 (
    .clk(clk), .reset(reset), .bus(if3), .busy(a_busy[2]), .par_err(a_par[2]));

  // Shared request drive for the auxiliary instances; a_sel picks which one sees valid.
  int          a_sel = 0;
  logic        a_valid, a_wr;
  logic [31:0] a_addr, a_wdata;
  logic [3:0]  a_be;
  logic        a_ready, a_rsp_valid, a_err;
  logic [31:0] a_rdata;

  assign if0.req_valid = a_valid && (a_sel == 0);
  assign if1.req_valid = a_valid && (a_sel == 1);
  assign if3.req_valid = a_valid && (a_sel == 2);
  assign if0.req_wr = a_wr;      assign if1.req_wr = a_wr;      assign if3.req_wr = a_wr;
  assign if0.req_addr = a_addr;  assign if1.req_addr = a_addr;  assign if3.req_addr = a_addr;
  assign if0.req_wdata = a_wdata; assign if1.req_wdata = a_wdata; assign if3.req_wdata = a_wdata;
  assign if0.req_be = a_be;      assign if1.req_be = a_be;      assign if3.req_be = a_be;

  always_comb begin
    a_ready = if0.req_ready; a_rsp_valid = if0.rsp_valid;
    a_rdata = if0.rsp_rdata; a_err = if0.rsp_err;
    if (a_sel == 1) begin
      a_ready = if1.req_ready; a_rsp_valid = if1.rsp_valid;
      a_rdata = if1.rsp_rdata; a_err = if1.rsp_err;
    end else if (a_sel == 2) begin
      a_ready = if3.req_ready; a_rsp_valid = if3.rsp_valid;
      a_rdata = if3.rsp_rdata; a_err = if3.rsp_err;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  exp_t main_q[$];
  exp_t aux_q[$];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[18];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic int ws_of(input int sel);
    return (sel == 0) ? 0 : (sel == 1) ? 1 : 3;
  endfunction

  always @(negedge clk) begin : mon_main
    exp_t e;
    if (reset && bus.rsp_valid) begin
      if (main_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL main_unexpected_rsp: got rsp_valid=1 at cycle %0d, want 0", cyc);
      end else begin
        e = main_q.pop_front();
        $display("main rsp: rdata=%h err=%b latency=%0d", bus.rsp_rdata, bus.rsp_err, cyc - e.acc);
        check32("main_rdata", bus.rsp_rdata, e.rdata);
        check32("main_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
        check32("main_latency", cyc - e.acc, e.lat);
      end
    end
  end

  always @(negedge clk) begin : mon_aux
    exp_t e;
    if (reset && a_rsp_valid) begin
      if (aux_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL aux_unexpected_rsp: got rsp_valid=1 at cycle %0d, want 0", cyc);
      end else begin
        e = aux_q.pop_front();
        $display("aux%0d rsp: rdata=%h err=%b latency=%0d", a_sel, a_rdata, a_err, cyc - e.acc);
        check32("aux_rdata", a_rdata, e.rdata);
        check32("aux_err", {31'd0, a_err}, {31'd0, e.err});
        check32("aux_latency", cyc - e.acc, e.lat);
      end
    end
  end

  task automatic main_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err);
    int waited = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_wr = wr; bus.req_addr = addr;
    bus.req_wdata = wdata; bus.req_be = be;
    while (!bus.req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL main_accept_timeout: got req_ready=0 for %0d cycles, want 1", waited);
      bus.req_valid = 1'b0;
      return;
    end
    main_q.push_back('{exp_rdata, exp_err, cyc + 1, WS + 1});
    @(posedge clk);
    #1;
    // Scramble the request after acceptance; the DUT must have latched it already.
    bus.req_valid = 1'b0; bus.req_wr = ~wr; bus.req_addr = $urandom();
    bus.req_wdata = $urandom(); bus.req_be = ~be;
  endtask

  task automatic aux_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err,
                            input logic hold, output int acc_cyc);
    int waited = 0;
    acc_cyc = -100;
    @(negedge clk);
    a_valid = 1'b1; a_wr = wr; a_addr = addr; a_wdata = wdata; a_be = be;
    while (!a_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!a_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL aux_accept_timeout: got req_ready=0 for %0d cycles, want 1", waited);
      a_valid = 1'b0;
      return;
    end
    acc_cyc = cyc + 1;
    aux_q.push_back('{exp_rdata, exp_err, acc_cyc, ws_of(a_sel) + 1});
    @(posedge clk);
    #1;
    if (!hold) a_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((main_q.size() != 0 || aux_q.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (main_q.size() != 0 || aux_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d/%0d pending responses, want 0", main_q.size(), aux_q.size());
      main_q.delete();
      aux_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got no finish by %0t, want finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int ae;
    int prev;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'h1234_5678, 4'hF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'h1234_5678, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0010, 32'hAABB_CCDD, 4'h5, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 32'h12BB_56DD, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 32'h0000_0000, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'h12BB_56DD, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_0000, 32'h5566_7788, 4'hF, 32'h0000_0000, 1'b0};
    vecs[7]  = '{1'b1, 32'h0000_0020, 32'hA5A5_5A5A, 4'hF, 32'h0000_0000, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_03FC, 32'h1122_3344, 4'hF, 32'h0000_0000, 1'b0};
    vecs[9]  = '{1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b1};
    vecs[10] = '{1'b0, 32'h4000_0010, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1};
    vecs[11] = '{1'b1, 32'h0000_0011, 32'hCAFE_F00D, 4'hF, 32'h0000_0000, 1'b1};
    vecs[12] = '{1'b1, 32'h0000_0400, 32'h0BAD_BEEF, 4'hF, 32'h0000_0000, 1'b1};
    vecs[13] = '{1'b0, 32'h0000_0012, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1};
    vecs[14] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'h12BB_56DD, 1'b0};
    vecs[15] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 32'h5566_7788, 1'b0};
    vecs[16] = '{1'b0, 32'h0000_03FC, 32'h0000_0000, 4'h0, 32'h1122_3344, 1'b0};
    vecs[17] = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'h0, 32'hA5A5_5A5A, 1'b0};

    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_addr = 32'd0;
    bus.req_wdata = 32'd0; bus.req_be = 4'd0;
    a_valid = 1'b0; a_wr = 1'b0; a_addr = 32'd0; a_wdata = 32'd0; a_be = 4'd0;

    // Reset state, sampled between clock edges
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    check32("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    check32("rst_busy", {31'd0, busy}, 32'd0);
    check32("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check32("rst_rdata", bus.rsp_rdata, 32'd0);
    check32("rst_err", {31'd0, bus.rsp_err}, 32'd0);
    check32("rst_par_err", {31'd0, par_err}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 18; i++) begin
      main_access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                  vecs[i].exp_rdata, vecs[i].exp_err);
    end
    drain();

    // Store to 0x20 interrupted by reset while waiting: dropped, no response
    main_access(1'b1, 32'h0000_0020, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    main_q.delete();
    check32("midrst_ready", {31'd0, bus.req_ready}, 32'd1);
    check32("midrst_busy", {31'd0, busy}, 32'd0);
    check32("midrst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check32("midrst_rdata", bus.rsp_rdata, 32'd0);
    check32("midrst_err", {31'd0, bus.rsp_err}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    main_access(1'b0, 32'h0000_0020, 32'h0, 4'h0, 32'hA5A5_5A5A, 1'b0);
    drain();

    // WAIT_STATES=0: fill four words, then four loads with req_valid held high
    a_sel = 0;
    for (int i = 0; i < 4; i++) begin
      aux_access(1'b1, 32'(i * 4), 32'hC0DE_0000 + 32'(i), 4'hF, 32'h0, 1'b0, 1'b0, ae);
    end
    drain();
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      aux_access(1'b0, 32'(i * 4), 32'h0, 4'h0, 32'hC0DE_0000 + 32'(i), 1'b0, (i < 3), ae);
      if (i > 0) check32("b2b_spacing", 32'(ae - prev), 32'd2);
      prev = ae;
    end
    drain();

    // Latency for WAIT_STATES 1 and 3
    for (int s = 1; s < 3; s++) begin
      a_sel = s;
      aux_access(1'b1, 32'h0000_0008, 32'h600D_0000 + 32'(s), 4'hF, 32'h0, 1'b0, 1'b0, ae);
      aux_access(1'b0, 32'h0000_0008, 32'h0, 4'h0, 32'h600D_0000 + 32'(s), 1'b0, 1'b0, ae);
      drain();
    end
    a_sel = 0;

`ifdef DMEM_PARITY_EN
    // Corrupt the lane-1 parity bit of word 4 (byte address 0x10)
    dut.g_par[1].par_mem[4] = ~dut.g_par[1].par_mem[4];
    main_access(1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'h12BB_56DD, 1'b1);
    drain();
    check32("par_err_set", {31'd0, par_err}, 32'd1);
    main_access(1'b0, 32'h0000_0000, 32'h0, 4'h0, 32'h5566_7788, 1'b0);
    drain();
    check32("par_err_sticky", {31'd0, par_err}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check32("par_err_cleared", {31'd0, par_err}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
`else
    check32("par_err_off", {31'd0, par_err}, 32'd0);
`endif

    check32("aux_idle", {29'd0, a_busy}, 32'd0);
    check32("aux_par_err", {29'd0, a_par}, 32'd0);
    check32("main_idle", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
